// File: rtl/ldpc_msg_pkg.sv
// ============================================================================
// ldpc_msg_pkg : shared sign-magnitude message definitions for LDPC node units
// Revision: 1.0
// ============================================================================
`default_nettype none

package ldpc_msg_pkg;

  localparam int MSG_W    = 4;
  localparam int SIGN_BIT = 2;
  localparam int MAG_W    = 2;
  localparam int MAG_MAX  = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } cn_state_t;

  // A zero magnitude is always carried as +0.
  function automatic logic [MAG_W:0] sm_norm(input logic [MAG_W:0] sm);
    return (sm[MAG_W-1:0] == '0) ? '0 : sm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cn_min2_tracker.sv
// ============================================================================
// cn_min2_tracker : running smallest / second-smallest magnitude and argmin
// Revision: 1.0
// ============================================================================
`default_nettype none

module cn_min2_tracker #(
  parameter int IDX_W = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_clr,
  input  logic                               i_en,
  input  logic [ldpc_msg_pkg::MAG_W-1:0]     i_mag,
  input  logic [IDX_W-1:0]                   i_idx,
  output logic [ldpc_msg_pkg::MAG_W-1:0]     o_min1,
  output logic [ldpc_msg_pkg::MAG_W-1:0]     o_min2,
  output logic [IDX_W-1:0]                   o_min_idx
);
  import ldpc_msg_pkg::*;

  localparam logic [MAG_W-1:0] c_mag_max = MAG_W'(MAG_MAX);

  logic [MAG_W-1:0] r_min1;
  logic [MAG_W-1:0] r_min2;
  logic [IDX_W-1:0] r_min_idx;

  // Strict compare on min1 means a tie falls through and lands in min2.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_min1    <= c_mag_max;
      r_min2    <= c_mag_max;
      r_min_idx <= '0;
    end else if (i_en) begin
      if (i_mag < r_min1) begin
        r_min2    <= r_min1;
        r_min1    <= i_mag;
        r_min_idx <= i_idx;
      end else if (i_mag < r_min2) begin
        r_min2 <= i_mag;
      end
    end
  end

  assign o_min1    = r_min1;
  assign o_min2    = r_min2;
  assign o_min_idx = r_min_idx;

endmodule

`default_nettype wire

// File: rtl/cn_minsum_serial.sv
// ============================================================================
// cn_minsum_serial : serial offset-min-sum check-node processor with parity flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module cn_minsum_serial #(
  parameter int DC     = 6,
  parameter int MSG_W  = 4,
  parameter int OFFSET = 0,
  localparam int IDX_W = $clog2(DC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MSG_W-1:0] out_msg,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             chk_ok
);
  import ldpc_msg_pkg::*;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DC - 1);
  localparam logic [MAG_W-1:0] c_offset   = MAG_W'(OFFSET);

  cn_state_t        r_state;
  cn_state_t        w_state_next;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_out_idx;
  logic [DC-1:0]    r_sign;
  logic             r_sign_prod;

  logic [MAG_W:0]   w_norm;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_cnt_last;
  logic             w_idx_last;
  logic [MAG_W-1:0] w_min1;
  logic [MAG_W-1:0] w_min2;
  logic [IDX_W-1:0] w_min_idx;
  logic [MAG_W-1:0] w_mag_sel;
  logic [MAG_W-1:0] w_mag_off;
  logic             w_sign_out;
  logic             w_unused;

  assign w_norm = sm_norm(in_msg[SIGN_BIT:0]);

  if (MSG_W > SIGN_BIT + 1) begin : g_pad_unused
    assign w_unused = ^in_msg[MSG_W-1:SIGN_BIT+1];
  end else begin : g_no_pad
    assign w_unused = 1'b0;
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_cnt_last = (r_cnt == c_last_idx);
  assign w_idx_last = (r_out_idx == c_last_idx);

  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && w_cnt_last) w_state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && w_idx_last) w_state_next = COLLECT;
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_out_idx   <= '0;
      r_sign      <= '0;
      r_sign_prod <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_sign[r_cnt] <= w_norm[SIGN_BIT];
        r_sign_prod   <= r_sign_prod ^ w_norm[SIGN_BIT];
        r_cnt         <= w_cnt_last ? '0 : r_cnt + 1'b1;
      end
      if (w_out_fire) begin
        if (w_idx_last) begin
          r_out_idx   <= '0;
          r_sign      <= '0;
          r_sign_prod <= 1'b0;
        end else begin
          r_out_idx <= r_out_idx + 1'b1;
        end
      end
    end
  end

  cn_min2_tracker #(
    .IDX_W (IDX_W)
  ) u_min2 (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_out_fire & w_idx_last),
    .i_en      (w_in_fire),
    .i_mag     (w_norm[MAG_W-1:0]),
    .i_idx     (r_cnt),
    .o_min1    (w_min1),
    .o_min2    (w_min2),
    .o_min_idx (w_min_idx)
  );

  // The edge holding the minimum sees the runner-up; all others see the minimum.
  assign w_mag_sel  = (r_out_idx == w_min_idx) ? w_min2 : w_min1;
  assign w_mag_off  = (w_mag_sel > c_offset) ? (w_mag_sel - c_offset) : '0;
  assign w_sign_out = r_sign_prod ^ r_sign[r_out_idx];

  always_comb begin
    out_msg = '0;
    if (r_state == EMIT) begin
      out_msg[SIGN_BIT]    = w_sign_out & (w_mag_off != '0);
      out_msg[MAG_W-1:0]   = w_mag_off;
    end
  end

  assign out_idx  = r_out_idx;
  assign out_last = (r_state == EMIT) & w_idx_last;
  assign chk_ok   = (r_state == EMIT) & ~r_sign_prod;

endmodule

`default_nettype wire
